// File: rtl/mdu.sv
// Multiply/divide unit for the E stage: fixed-latency mult/multu/div/divu plus the HI/LO pair.
// Results are computed from operands latched at start, so the forwarded inputs may change freely.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  MDUop,
  input  logic        start,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        busy,
  output logic        stall
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic [2:0]    op_q, op_d;

  logic        is_md;
  logic        sx, a_neg, b_neg, div_zero;
  logic [63:0] prod;
  logic [31:0] num, den, den_safe, q_mag, r_mag, quot_res, rem_res;

  assign is_md = start && (MDUop inside {[OP_MULT:OP_DIVU]});
  assign busy  = (state_q == RUN);
  assign stall = busy | is_md;
  assign HI    = hi_q;
  assign LO    = lo_q;

  // One 64-bit multiplier: signed mult is the low half of the sign-extended product.
  assign sx   = (op_q == OP_MULT);
  assign prod = {{32{sx & a_q[31]}}, a_q} * {{32{sx & b_q[31]}}, b_q};

  // Signed divide works on magnitudes so INT_MIN / -1 wraps to INT_MIN with no overflow trap.
  assign a_neg    = (op_q == OP_DIV) & a_q[31];
  assign b_neg    = (op_q == OP_DIV) & b_q[31];
  assign num      = a_neg ? -a_q : a_q;
  assign den      = b_neg ? -b_q : b_q;
  assign div_zero = (b_q == 32'd0);
  assign den_safe = div_zero ? 32'd1 : den;
  assign q_mag    = num / den_safe;
  assign r_mag    = num % den_safe;
  assign quot_res = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign rem_res  = a_neg ? -r_mag : r_mag;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (is_md) begin
          a_d     = A;
          b_d     = B;
          op_d    = MDUop;
          cnt_d   = (MDUop == OP_MULT || MDUop == OP_MULTU) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
          state_d = RUN;
        end else if (start && MDUop == OP_MTHI) begin
          hi_d = A;
        end else if (start && MDUop == OP_MTLO) begin
          lo_d = A;
        end
      end
      RUN: begin
        // Starts arriving here are dropped; the hazard unit should never send them.
        if (cnt_q <= CW'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          case (op_q)
            OP_MULT, OP_MULTU: {hi_d, lo_d} = prod;
            OP_DIV, OP_DIVU: begin
              if (!div_zero) begin
                hi_d = rem_res;
                lo_d = quot_res;
              end
            end
            default: ;
          endcase
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: randomized and directed ops against an arithmetic HI/LO model.
module tb_mdu;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A, B;
  logic [2:0]  MDUop;
  logic        start;
  logic [31:0] HI, LO;
  logic        busy, stall;

  int total = 0;
  int bad   = 0;
  logic [31:0] hi_m = 32'd0;
  logic [31:0] lo_m = 32'd0;

  always #5 clk = ~clk;

  mdu dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .MDUop(MDUop), .start(start),
    .HI(HI), .LO(LO), .busy(busy), .stall(stall)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic int lat(input logic [2:0] op);
    if (op == 3'd1 || op == 3'd2) return 5;
    if (op == 3'd3 || op == 3'd4) return 10;
    return 0;
  endfunction

  // Architectural effect of one accepted op on HI/LO, from plain 64-bit arithmetic.
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = 64'(a);
    ub = 64'(b);
    case (op)
      3'd1: begin p = 64'(sa * sb); hi_m = p[63:32]; lo_m = p[31:0]; end
      3'd2: begin p = ua * ub;      hi_m = p[63:32]; lo_m = p[31:0]; end
      3'd3: if (b != 32'd0) begin
        q = sa / sb; r = sa % sb;
        lo_m = q[31:0]; hi_m = r[31:0];
      end
      3'd4: if (b != 32'd0) begin lo_m = a / b; hi_m = a % b; end
      3'd5: hi_m = a;
      3'd6: lo_m = a;
      default: ;
    endcase
  endfunction

  // Drive one start in the current (idle) cycle; returns stall seen in that cycle.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output logic st);
    A = a; B = b; MDUop = op; start = 1'b1;
    #1 st = stall;
    @(posedge clk); #1;
    start = 1'b0;
    MDUop = 3'($urandom_range(0, 7));
    A = $urandom; B = $urandom;
    model(op, a, b);
  endtask

  // Counts busy cycles starting from the current one; bounded.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 64) begin
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; MDUop = 3'd0; A = 32'd0; B = 32'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    hi_m = 32'd0; lo_m = 32'd0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++;
      if (HI !== 32'd0 || LO !== 32'd0 || busy !== 1'b0 || stall !== 1'b0) begin
        bad++;
        $display("FAIL reset_idle[%0d]: got HI=%h LO=%h busy=%b stall=%b exp all zero", i, HI, LO, busy, stall);
      end
    end
  endtask

  task automatic test_mult;
    logic [2:0] op; logic [31:0] a, b; logic st; int n;
    for (int i = 0; i < 8; i++) begin
      op = (i == 0) ? 3'd1 : (i == 1) ? 3'd2 : 3'($urandom_range(1, 2));
      a  = (i < 2) ? 32'hFFFF_FFFE : $urandom;
      b  = (i < 2) ? 32'd3 : ((i % 2) ? $urandom : 32'($urandom_range(0, 1000)) - 32'd500);
      issue(op, a, b, st);
      wait_idle(n);
      total++;
      if (st !== 1'b1 || n !== 5) begin
        bad++;
        $display("FAIL mult_timing[%0d]: got stall=%b busy_cycles=%0d exp stall=1 busy_cycles=5", i, st, n);
      end
      total++;
      if (HI !== hi_m || LO !== lo_m) begin
        bad++;
        $display("FAIL mult_result[%0d] op=%0d a=%h b=%h: got HI=%h LO=%h exp HI=%h LO=%h",
                 i, op, a, b, HI, LO, hi_m, lo_m);
      end
    end
  endtask

  task automatic test_div;
    logic [2:0] op; logic [31:0] a, b; logic st; int n;
    for (int i = 0; i < 9; i++) begin
      case (i)
        0: begin op = 3'd3; a = 32'hFFFF_FFF9; b = 32'd2; end
        1: begin op = 3'd4; a = 32'd7;         b = 32'd2; end
        2: begin op = 3'd3; a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        default: begin
          op = 3'($urandom_range(3, 4));
          a  = $urandom;
          b  = (i % 2) ? $urandom : 32'($urandom_range(1, 50)) * ((i % 4 == 0) ? 32'hFFFF_FFFF : 32'd1);
          if (b == 32'd0) b = 32'd3;
        end
      endcase
      issue(op, a, b, st);
      wait_idle(n);
      total++;
      if (st !== 1'b1 || n !== 10) begin
        bad++;
        $display("FAIL div_timing[%0d]: got stall=%b busy_cycles=%0d exp stall=1 busy_cycles=10", i, st, n);
      end
      total++;
      if (HI !== hi_m || LO !== lo_m) begin
        bad++;
        $display("FAIL div_result[%0d] op=%0d a=%h b=%h: got HI=%h LO=%h exp HI=%h LO=%h",
                 i, op, a, b, HI, LO, hi_m, lo_m);
      end
    end
  endtask

  task automatic test_divzero;
    logic st; int n;
    issue(3'd5, 32'h1111_1111, $urandom, st);
    total++;
    if (HI !== 32'h1111_1111 || st !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL mthi: got HI=%h stall=%b busy=%b exp HI=11111111 stall=0 busy=0", HI, st, busy);
    end
    issue(3'd6, 32'h2222_2222, $urandom, st);
    total++;
    if (LO !== 32'h2222_2222 || st !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL mtlo: got LO=%h stall=%b busy=%b exp LO=22222222 stall=0 busy=0", LO, st, busy);
    end
    for (int i = 0; i < 2; i++) begin
      issue((i == 0) ? 3'd4 : 3'd3, $urandom, 32'd0, st);
      wait_idle(n);
      total++;
      if (n !== 10 || HI !== 32'h1111_1111 || LO !== 32'h2222_2222) begin
        bad++;
        $display("FAIL div_by_zero[%0d]: got busy_cycles=%0d HI=%h LO=%h exp 10 11111111 22222222", i, n, HI, LO);
      end
    end
  endtask

  task automatic test_start_while_busy;
    logic st; int n;
    issue(3'd1, $urandom, $urandom, st);
    @(posedge clk); #1;
    start = 1'b1; MDUop = 3'd6; A = 32'h0000_DEAD;
    #1;
    total++;
    if (stall !== 1'b1) begin
      bad++;
      $display("FAIL busy_stall: got stall=%b exp 1", stall);
    end
    @(posedge clk); #1;
    MDUop = 3'd4; A = $urandom; B = 32'd5;
    @(posedge clk); #1;
    start = 1'b0; MDUop = 3'd0;
    wait_idle(n);
    total++;
    if (n + 3 !== 5 || HI !== hi_m || LO !== lo_m) begin
      bad++;
      $display("FAIL start_while_busy: got busy_cycles=%0d HI=%h LO=%h exp 5 HI=%h LO=%h",
               n + 3, HI, LO, hi_m, lo_m);
    end
  endtask

  task automatic test_reset_midop;
    logic st; int n;
    issue(3'd5, 32'hCAFE_0001, 32'd0, st);
    issue(3'd3, $urandom, 32'd9, st);
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b0;
    #1;
    hi_m = 32'd0; lo_m = 32'd0;
    total++;
    if (HI !== 32'd0 || LO !== 32'd0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_midop: got HI=%h LO=%h busy=%b exp 0 0 0", HI, LO, busy);
    end
    @(posedge clk); #3 reset = 1'b1;
    @(posedge clk); #1;
    issue(3'd1, 32'd6, 32'd7, st);
    wait_idle(n);
    total++;
    if (n !== 5 || HI !== 32'd0 || LO !== 32'd42) begin
      bad++;
      $display("FAIL after_reset_mult: got busy_cycles=%0d HI=%h LO=%h exp 5 0 0000002a", n, HI, LO);
    end
  endtask

  task automatic test_back_to_back;
    logic [2:0] op; logic [31:0] a, b; logic st; int n;
    for (int i = 0; i < 12; i++) begin
      op = 3'($urandom_range(1, 6));
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      issue(op, a, b, st);
      wait_idle(n);
      total++;
      if (n !== lat(op) || st !== (lat(op) != 0)) begin
        bad++;
        $display("FAIL b2b_timing[%0d] op=%0d: got busy_cycles=%0d stall=%b exp %0d %b",
                 i, op, n, st, lat(op), lat(op) != 0);
      end
      total++;
      if (HI !== hi_m || LO !== lo_m) begin
        bad++;
        $display("FAIL b2b_result[%0d] op=%0d a=%h b=%h: got HI=%h LO=%h exp HI=%h LO=%h",
                 i, op, a, b, HI, LO, hi_m, lo_m);
      end
    end
  endtask

  initial begin
    test_reset;
    test_mult;
    test_div;
    test_divzero;
    test_start_while_busy;
    test_reset_midop;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit for the E stage of the five-stage MIPS pipeline, sitting beside the ALU and consuming the same forwarded operand pair (A = rs value, B = rt value). It runs mult/multu/div/divu over a fixed multi-cycle latency and holds the HI/LO register pair that mthi/mtlo write and mfhi/mflo read. Its busy and stall outputs feed the hazard unit, which freezes D while the unit is occupied.

## Interface
- MULT_CYCLES, 5, cycles from accepted start to HI/LO update for mult/multu (must be ≥ 1)
- DIV_CYCLES, 10, cycles from accepted start to HI/LO update for div/divu (must be ≥ 1)

- clk  input  1  pipeline clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low; clears all state immediately when low
- A  input  32  operand 1 (rs), already forwarded
- B  input  32  operand 2 (rt), already forwarded
- MDUop  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 none
- start  input  1  single-cycle qualifier; op valid this cycle
- HI  output  32  current HI register
- LO  output  32  current LO register
- busy  output  1  registered; high while an operation is in flight
- stall  output  1  combinational: busy | (start & MDUop in 1..4)

## Operation
- States: IDLE, RUN. The counter is wide enough for max(MULT_CYCLES, DIV_CYCLES).
- IDLE, start with MDUop 1–4: latch A, B and MDUop into internal registers, load counter = latency, go to RUN, busy=1 from the next cycle.
- IDLE, start with MDUop 5: HI ← A at the edge. MDUop 6: LO ← A. No busy.
- IDLE, start with MDUop 0 or 7: no effect.
- RUN: decrement the counter each edge. At the edge where the counter reaches the terminal value, write HI/LO from the latched operands, set busy=0 and return to IDLE.
- start in RUN (any op, including mthi/mtlo): ignored, with no effect on state or HI/LO. The hazard unit guarantees this never happens; the block is still required to tolerate it.
- Arithmetic is computed only from the latched operands. Operand inputs may change freely after start.
  - mult: {HI,LO} = signed(A) × signed(B), 64-bit.
  - multu: {HI,LO} = unsigned 64-bit product.
  - div: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - divu: LO = unsigned quotient; HI = unsigned remainder.
  - div with A=0x80000000 and B=0xFFFFFFFF: LO=0x80000000, HI=0x00000000.
  - Divide by zero (div or divu, B=0): HI and LO are left unchanged, but busy is still held for the full DIV_CYCLES.
- HI and LO are register outputs only. The mfhi/mflo selection is done in the E-stage result mux outside this block.

## Timing
- Reset values: HI=0, LO=0, busy=0, state IDLE, counter 0, latched operands 0. stall follows from these (0 when start=0).
- Reset asserted mid-operation aborts the operation. HI/LO read 0 and busy reads 0 immediately (asynchronous). The first start after reset deassertion is accepted normally.
- Start accepted at edge k with latency N: busy=1 during cycles k+1 … k+N. HI/LO take the new values and busy falls at edge k+N. A new start is accepted at edge k+N+1 at the earliest; this is back-to-back, with no bubble beyond busy.
- stall is high in the start cycle, so the instruction behind the start stalls without a one-cycle gap.
- mthi/mtlo: HI/LO update at the same edge as start, visible in the next cycle.

## Test plan
- Reset then idle: hold reset=0 for 2 cycles, release -> HI=LO=0, busy=0, stall=0 for 5 idle cycles.
- mult with A=0xFFFFFFFE (−2), B=3 -> stall=1 in the start cycle; busy=1 for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. Repeat as multu -> HI=0x00000002, LO=0xFFFFFFFA.
- div with A=−7 (0xFFFFFFF9), B=2 -> after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu with A=7, B=2 -> LO=3, HI=1. div with A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- Divide by zero: preload HI=0x11111111 via mthi and LO=0x22222222 via mtlo, then divu with B=0 -> busy for 10 cycles, HI/LO unchanged.
- Start while busy: issue mult, then issue mtlo A=0xDEAD and a divu start in busy cycles 2 and 3 -> both ignored; busy drops after exactly 5 cycles; the product from the mult is correct. Change A/B after start -> result unaffected.
- Reset mid-op: start div, pull reset low in busy cycle 4 -> HI=LO=0 and busy=0 asynchronously; after release, a mult 6×7 gives LO=42, HI=0 after 5 cycles.
